// File: rtl/load_align_unit.sv
// Load/store sequencer between execute and the data memory port: issues word-aligned
// accesses, lane-aligns store data/strobes and right-justifies load data for signext.

package isa_shared;
  typedef enum logic [2:0] {
    SX_3100  = 3'd0,
    SX_1500  = 3'd1,
    SX_0700  = 3'd2,
    SXU_1500 = 3'd3,
    SXU_0700 = 3'd4
  } sx_op_e;
endpackage

module load_align_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [2:0]            rsp_sx_op,
  output logic                  rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    unsigned_q;
  logic [1:0]              lane_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wstrb_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  isa_shared::sx_op_e      rsp_sx_op_q;
  logic                    rsp_err_q;

  logic                    accept;
  logic                    misaligned;
  logic                    ack_hit;
  logic                    timeout_hit;
  logic [3:0]              wstrb_calc;
  logic [DATA_WIDTH-1:0]   wdata_calc;
  logic [DATA_WIDTH-1:0]   load_data;
  isa_shared::sx_op_e      load_sx;

  assign accept = (state_q == IDLE) && req_valid;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane placement: replicate the datum across the word, strobe only the addressed lanes.
  always_comb begin
    wstrb_calc = 4'b0000;
    wdata_calc = '0;
    if (req_we) begin
      case (req_size)
        2'b00: begin
          wstrb_calc = 4'b0001 << req_addr[1:0];
          wdata_calc = DATA_WIDTH'({4{req_wdata[7:0]}});
        end
        2'b01: begin
          wstrb_calc = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_calc = DATA_WIDTH'({2{req_wdata[15:0]}});
        end
        default: begin
          wstrb_calc = 4'b1111;
          wdata_calc = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    load_data = mem_rdata;
    load_sx   = isa_shared::SX_3100;
    case (size_q)
      2'b00: begin
        load_data = DATA_WIDTH'(mem_rdata[{lane_q, 3'b000} +: 8]);
        load_sx   = unsigned_q ? isa_shared::SXU_0700 : isa_shared::SX_0700;
      end
      2'b01: begin
        load_data = DATA_WIDTH'(mem_rdata[{lane_q[1], 4'b0000} +: 16]);
        load_sx   = unsigned_q ? isa_shared::SXU_1500 : isa_shared::SX_1500;
      end
      default: begin
        load_data = mem_rdata;
        load_sx   = isa_shared::SX_3100;
      end
    endcase
  end

  // Ack is tested before the timeout so a same-cycle ack completes successfully.
  always_comb begin
    state_d     = state_q;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:   if (req_valid) state_d = misaligned ? RESP : ACCESS;
      ACCESS: begin
        if (mem_ack) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      rsp_data_q  <= '0;
      rsp_sx_op_q <= isa_shared::SX_3100;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q      <= '0;
        we_q       <= req_we;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        lane_q     <= req_addr[1:0];
        addr_q     <= {req_addr[DATA_WIDTH-1:2], 2'b00};
        wdata_q    <= wdata_calc;
        wstrb_q    <= wstrb_calc;
        if (misaligned) begin
          rsp_data_q  <= '0;
          rsp_sx_op_q <= isa_shared::SX_3100;
          rsp_err_q   <= 1'b1;
        end
      end
      if (state_q == ACCESS && !mem_ack) cnt_q <= cnt_q + 1'b1;
      if (ack_hit) begin
        rsp_data_q  <= we_q ? '0 : load_data;
        rsp_sx_op_q <= we_q ? isa_shared::SX_3100 : load_sx;
        rsp_err_q   <= 1'b0;
      end
      if (timeout_hit) begin
        rsp_data_q  <= '0;
        rsp_sx_op_q <= isa_shared::SX_3100;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_sx_op = rsp_sx_op_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed vector table, reset/ack corner
// sequences, and randomized transactions against an arithmetic reference model.

module tb_load_align_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_sx_op;

  int checks   = 0;
  int failures = 0;

  load_align_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_sx_op(rsp_sx_op), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;   // ACCESS cycle index carrying mem_ack; -1 = never
    logic [31:0] e_data;
    logic [2:0]  e_sx;
    logic        e_err;
    logic        e_iss;     // rejected at issue, no memory access
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int ack_dly, input logic [31:0] e_data, input logic [2:0] e_sx,
                     input logic e_err, input logic e_iss, input logic [3:0] e_wstrb,
                     input logic [31:0] e_wdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_dly = ack_dly; v.e_data = e_data; v.e_sx = e_sx; v.e_err = e_err; v.e_iss = e_iss;
    v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
    tbl.push_back(v);
  endtask

  // Reference model: derives the expected response from byte counts and shifts.
  function automatic vec_t model(input vec_t s);
    vec_t v = s;
    int nb  = 1 << s.size;
    int off = int'(s.addr % 4);
    logic [31:0] mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    v.e_iss = (s.size == 2'b11) || (off % nb != 0);
    v.e_err = v.e_iss || (s.ack_dly < 0);
    v.e_sx  = isa_shared::SX_3100;
    v.e_data = 32'h0;
    v.e_wstrb = 4'h0;
    v.e_wdata = 32'h0;
    if (!v.e_iss && s.we) begin
      v.e_wstrb = 4'(((1 << nb) - 1) << off);
      v.e_wdata = (nb == 1) ? s.wdata[7:0] * 32'h0101_0101 :
                  (nb == 2) ? s.wdata[15:0] * 32'h0001_0001 : s.wdata;
    end
    if (!v.e_err && !s.we) begin
      v.e_data = (s.rdata >> (8 * off)) & mask;
      if (nb == 1)      v.e_sx = s.uns ? isa_shared::SXU_0700 : isa_shared::SX_0700;
      else if (nb == 2) v.e_sx = s.uns ? isa_shared::SXU_1500 : isa_shared::SX_1500;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int   k, req_cyc, exp_lat;
    logic hold_bad;
    @(negedge clk);
    check({nm, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_cyc = 0; hold_bad = 1'b0;
    for (k = 0; k < TO + 8; k++) begin
      if (rsp_valid) break;
      if (mem_req) begin
        req_cyc++;
        if (mem_addr !== (v.addr & 32'hFFFF_FFFC) || mem_we !== v.we ||
            mem_wstrb !== v.e_wstrb || (v.we && mem_wdata !== v.e_wdata)) hold_bad = 1'b1;
      end
      mem_ack   = (v.ack_dly == k);
      mem_rdata = mem_ack ? v.rdata : $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    exp_lat = v.e_iss ? 0 : ((v.ack_dly < 0) ? TO : v.ack_dly + 1);
    check({nm, ":latency"},  32'(k),        32'(exp_lat));
    check({nm, ":req_cyc"},  32'(req_cyc),  32'(exp_lat));
    check({nm, ":mem_hold"}, 32'(hold_bad), 32'd0);
    check({nm, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({nm, ":mem_req_off"}, 32'(mem_req), 32'd0);
    check({nm, ":rsp_data"}, rsp_data, v.e_data);
    check({nm, ":rsp_sx_op"}, 32'(rsp_sx_op), 32'(v.e_sx));
    check({nm, ":rsp_err"}, 32'(rsp_err), 32'(v.e_err));
    @(negedge clk);
    check({nm, ":one_pulse"}, 32'(rsp_valid), 32'd0);
    check({nm, ":data_held"}, rsp_data, v.e_data);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    //   we size uns addr          wdata         rdata         ack  e_data        e_sx                  err iss wstrb  e_wdata
    add(0, 2'b00, 0, 32'h103, 32'h0,         32'h80AABBCC, 0,  32'h80,       isa_shared::SX_0700,  0, 0, 4'h0, 32'h0);
    add(0, 2'b00, 1, 32'h103, 32'h0,         32'h80AABBCC, 0,  32'h80,       isa_shared::SXU_0700, 0, 0, 4'h0, 32'h0);
    add(0, 2'b01, 0, 32'h202, 32'h0,         32'hFEDC1234, 3,  32'hFEDC,     isa_shared::SX_1500,  0, 0, 4'h0, 32'h0);
    add(1, 2'b00, 0, 32'h301, 32'h000000A5,  32'h0,        0,  32'h0,        isa_shared::SX_3100,  0, 0, 4'h2, 32'hA5A5A5A5);
    add(0, 2'b10, 0, 32'h402, 32'h0,         32'h0,        -1, 32'h0,        isa_shared::SX_3100,  1, 1, 4'h0, 32'h0);
    add(0, 2'b11, 0, 32'h400, 32'h0,         32'h0,        -1, 32'h0,        isa_shared::SX_3100,  1, 1, 4'h0, 32'h0);
    add(0, 2'b10, 0, 32'h500, 32'h0,         32'h0,        -1, 32'h0,        isa_shared::SX_3100,  1, 0, 4'h0, 32'h0);
    add(0, 2'b01, 1, 32'h600, 32'h0,         32'h1234ABCD, 1,  32'hABCD,     isa_shared::SXU_1500, 0, 0, 4'h0, 32'h0);
    add(1, 2'b01, 0, 32'h702, 32'hDEADBEEF,  32'h0,        0,  32'h0,        isa_shared::SX_3100,  0, 0, 4'hC, 32'hBEEFBEEF);
    add(1, 2'b10, 0, 32'h800, 32'h12345678,  32'h0,        2,  32'h0,        isa_shared::SX_3100,  0, 0, 4'hF, 32'h12345678);
    add(0, 2'b10, 1, 32'h900, 32'h0,         32'hCAFEF00D, 0,  32'hCAFEF00D, isa_shared::SX_3100,  0, 0, 4'h0, 32'h0);
    add(1, 2'b01, 0, 32'h701, 32'h1111,      32'h0,        -1, 32'h0,        isa_shared::SX_3100,  1, 1, 4'h0, 32'h0);
    add(0, 2'b00, 0, 32'hA00, 32'h0,         32'h00000011, 15, 32'h11,       isa_shared::SX_0700,  0, 0, 4'h0, 32'h0);
    add(0, 2'b00, 0, 32'hB02, 32'h0,         32'h00F10000, 0,  32'hF1,       isa_shared::SX_0700,  0, 0, 4'h0, 32'h0);

    #12;
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:mem_req",   32'(mem_req),   32'd0);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_data",  rsp_data,       32'd0);
    check("rst:rsp_sx_op", 32'(rsp_sx_op), 32'(isa_shared::SX_3100));
    check("rst:rsp_err",   32'(rsp_err),   32'd0);
    check("rst:mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-access, then a stale ack while idle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid:mem_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid:mem_req",   32'(mem_req),   32'd0);
    check("rstmid:req_ready", 32'(req_ready), 32'd1);
    check("rstmid:rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    check("lateack:rsp_valid", 32'(rsp_valid), 32'd0);
    check("lateack:mem_req",   32'(mem_req),   32'd0);
    check("lateack:req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("lateack:rsp_valid2", 32'(rsp_valid), 32'd0);
    check("lateack:rsp_data",   rsp_data,       32'd0);

    for (int n = 0; n < 60; n++) begin
      int r;
      v.we = 1'($urandom); v.size = 2'($urandom_range(0, 3)); v.uns = 1'($urandom);
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
      r = $urandom_range(0, 9);
      v.ack_dly = (r <= 5) ? r : (r == 6) ? 15 : (r == 7) ? -1 : 0;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Multi-cycle load/store sequencer between the core's execute stage and the data memory port.
- Loads: issues a word-aligned memory read, waits for the acknowledge, then extracts and right-justifies the addressed byte, halfword or word.
- Presents that data with the matching sx_op code so the downstream signext block produces the final 32-bit register value.
- Stores: generates byte strobes and lane-shifted write data. Misaligned and timed-out accesses are reported as errors.

Parameters:
- DATA_WIDTH, 32, datapath and address width.
- TIMEOUT_CYCLES, 16, maximum cycles spent waiting for mem_ack before aborting.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  access request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  load is zero-extended (LBU/LHU)
- req_addr  input  DATA_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-justified
- mem_req  output  1  memory access strobe, held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  DATA_WIDTH  word address, bits [1:0] forced to 0
- mem_wdata  output  DATA_WIDTH  lane-shifted store data
- mem_wstrb  output  4  byte write strobes
- mem_ack  input  1  memory completion, single-cycle pulse
- mem_rdata  input  DATA_WIDTH  read word, valid with mem_ack
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  DATA_WIDTH  right-justified, unextended load data, fed to signext unextended_data
- rsp_sx_op  output  3  isa_shared sx_op code, fed to signext sx_op
- rsp_err  output  1  completion is an error (misaligned, illegal size, or timeout)

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; all outputs 0 except req_ready=1.
  - rsp_sx_op = isa_shared::SX_3100.
  - Timeout counter cleared.
  - Asserting reset mid-access drops mem_req immediately. No rsp_valid is produced for the aborted access.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1; request is captured when req_valid & req_ready.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: go to RESP with rsp_err=1. mem_req is never asserted.
  - Otherwise go to ACCESS; mem_req=1 and mem_* driven from registered request fields starting the next cycle.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable.
  - Counter increments each cycle without mem_ack.
  - mem_ack: capture mem_rdata and go to RESP, with rsp_err=0.
  - Counter reaching TIMEOUT_CYCLES-1 without ack: go to RESP with rsp_err=1 and rsp_data=0.
  - An ack in the same cycle as the timeout wins (success).
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 during RESP.
  - rsp_data, rsp_sx_op and rsp_err hold their values until the next RESP.
- Latency: a load with mem_ack on the first ACCESS cycle gives rsp_valid 2 cycles after the accepting edge. Error-on-issue gives rsp_valid 1 cycle after acceptance.
- Load extraction (lane = addr[1:0]):
  - byte: rsp_data = {24'b0, rdata[8*lane+7 : 8*lane]}.
  - half: rsp_data = {16'b0, rdata[16*addr[1]+15 : 16*addr[1]]}.
  - word: rsp_data = rdata.
- rsp_sx_op mapping:
  - byte: SX_0700 (signed) / SXU_0700 (unsigned).
  - half: SX_1500 (signed) / SXU_1500 (unsigned).
  - word: SX_3100, regardless of req_unsigned.
  - stores and errors: SX_3100.
- Store lanes:
  - byte: wstrb = 0001 << lane; wdata = {4{wdata[7:0]}}.
  - half: wstrb = 0011 << addr[1]*2; wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111.
  - Stores return rsp_data=0.
- Loads drive mem_wstrb=0 and mem_we=0.
- mem_ack outside ACCESS is ignored.

Test Plan:
- Load byte, addr 0x103, unsigned=0, rdata 0x80AABBCC on first-cycle ack -> mem_addr 0x100; rsp_data 0x00000080, rsp_sx_op SX_0700, rsp_valid 2 cycles after accept. Repeat with unsigned=1 -> SXU_0700.
- Load half, addr 0x202, rdata 0xFEDC1234, ack after 3 wait cycles -> rsp_data 0x0000FEDC, rsp_sx_op SX_1500, rsp_err 0; mem_req held 4 cycles.
- Store byte, addr 0x301, wdata 0x000000A5 -> mem_wstrb 0010, mem_wdata 0xA5A5A5A5, mem_we 1; rsp_valid with rsp_data 0.
- Load word, addr 0x402 -> no mem_req; rsp_valid 1 cycle after accept, rsp_err 1. Same for req_size 11.
- Load word, mem_ack never asserted -> mem_req drops after TIMEOUT_CYCLES (16) cycles, rsp_err 1, rsp_data 0; next request accepted normally.
- rst_n pulsed low during ACCESS -> mem_req 0 immediately, req_ready 1, no rsp_valid; a late mem_ack is ignored.
